// File: rtl/mem_ctrl.sv
// Memory request responder: serves MEM loads/stores and IF fetches one byte at a time
// over a byte-wide synchronous-read RAM port, reporting completion with a source tag.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IF_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rw_in,
    input  logic [ADDR_W-1:0] addr_mem_in,
    input  logic [2:0]        data_length_in,
    input  logic [31:0]       data_mem_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [1:0]        IF_or_MEM,
    output logic [31:0]       data_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] TAG_MEM = 2'b01;
    localparam logic [1:0] TAG_IF  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic [2:0]        cnt_q;
    logic [2:0]        cap_q;
    logic [31:0]       sdata_q;
    logic [31:0]       data_q;
    logic [1:0]        tag_q;

    logic       mem_rd, mem_wr;
    logic [2:0] mem_len;
    logic       last_cap;

    assign mem_rd  = (rw_in == 2'b01);
    assign mem_wr  = (rw_in == 2'b10);
    // Unsupported lengths fall back to a full word.
    assign mem_len = (data_length_in == 3'd1 || data_length_in == 3'd2 ||
                      data_length_in == 3'd4) ? data_length_in : 3'd4;
    // A byte issued last cycle is on ram_din whenever capture lags issue.
    assign last_cap = (cap_q < cnt_q) && (cap_q == len_q - 3'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_rd)         state_d = READ;
                else if (mem_wr)    state_d = WRITE;
                else if (if_req_in) state_d = READ;
            end
            READ:    if (last_cap) state_d = DONE;
            WRITE:   if (cnt_q == len_q - 3'd1) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            sdata_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    cap_q  <= '0;
                    data_q <= '0;
                    if (mem_rd || mem_wr) begin
                        base_q  <= addr_mem_in;
                        len_q   <= mem_len;
                        sdata_q <= data_mem_in;
                        tag_q   <= TAG_MEM;
                    end else if (if_req_in) begin
                        base_q  <= if_addr_in;
                        len_q   <= 3'(IF_LEN);
                        sdata_q <= '0;
                        tag_q   <= TAG_IF;
                    end
                end
                READ: begin
                    if (cnt_q < len_q) cnt_q <= cnt_q + 3'd1;
                    if (cap_q < cnt_q) begin
                        data_q[{cap_q[1:0], 3'b000} +: 8] <= ram_din;
                        cap_q <= cap_q + 3'd1;
                    end
                end
                WRITE:   cnt_q <= cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

    assign busy_out  = (state_q == READ) || (state_q == WRITE);
    assign done_out  = (state_q == DONE);
    assign IF_or_MEM = done_out ? tag_q : 2'b00;
    // data_q stays zero through a write, so DONE reports 0 for stores.
    assign data_out  = done_out ? data_q : 32'h0;
    assign ram_wr    = (state_q == WRITE);
    assign ram_addr  = busy_out ? base_q + ADDR_W'(cnt_q) : '0;
    assign ram_dout  = ram_wr ? sdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a 4 KiB synchronous-read byte RAM model aliased on the
// low address bits, with per-scenario tasks checking latency, RAM traffic and results.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rw_in;
    logic [31:0] addr_mem_in;
    logic [2:0]  data_length_in;
    logic [31:0] data_mem_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  IF_or_MEM;
    logic [31:0] data_out;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    // Per-transaction trace, indexed by cycle after the sampling edge.
    logic [31:0] tr_addr [16];
    logic        tr_wr   [16];
    logic [7:0]  tr_dout [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
        ram_din <= mem[ram_addr[11:0]];
    end

    mem_ctrl #(.ADDR_W(32), .IF_LEN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rw_in          (rw_in),
        .addr_mem_in    (addr_mem_in),
        .data_length_in (data_length_in),
        .data_mem_in    (data_mem_in),
        .if_req_in      (if_req_in),
        .if_addr_in     (if_addr_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .IF_or_MEM      (IF_or_MEM),
        .data_out       (data_out),
        .ram_addr       (ram_addr),
        .ram_wr         (ram_wr),
        .ram_dout       (ram_dout),
        .ram_din        (ram_din)
    );

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at the first negedge after the sampling edge; returns edges until done.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done_out && cycles < 15) begin
            tr_addr[cycles] = ram_addr;
            tr_wr[cycles]   = ram_wr;
            tr_dout[cycles] = ram_dout;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy_out, done_out, IF_or_MEM, data_out, ram_addr, ram_wr, ram_dout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b tag=%b data=%h addr=%h wr=%b dout=%h, want all 0",
                     busy_out, done_out, IF_or_MEM, data_out, ram_addr, ram_wr, ram_dout);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (busy_out !== 1'b0 || done_out !== 1'b0 || ram_wr !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold: busy=%b done=%b wr=%b, want 0 0 0",
                         busy_out, done_out, ram_wr);
            end
        end
    endtask

    task automatic test_load(input string name, input logic [31:0] a, input logic [2:0] len,
                             input int n, input logic [31:0] exp_data);
        int cyc;
        rw_in = 2'b01; addr_mem_in = a; data_length_in = len;
        @(negedge clk);
        rw_in = 2'b00; addr_mem_in = 32'hDEAD_BEEF; data_length_in = 3'd1;
        wait_done(cyc);
        total++;
        if (cyc !== n + 1) begin
            bad++; $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, n + 1);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (tr_addr[i] !== a + 32'(i) || tr_wr[i] !== 1'b0) begin
                bad++;
                $display("FAIL %s_addr%0d: addr=%h wr=%b, want %h 0", name, i, tr_addr[i],
                         tr_wr[i], a + 32'(i));
            end
        end
        total++;
        if (data_out !== exp_data || IF_or_MEM !== 2'b01 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: data=%h tag=%b busy=%b, want %h 01 0", name, data_out,
                     IF_or_MEM, busy_out, exp_data);
        end
        @(negedge clk);
        total++;
        if (done_out !== 1'b0 || IF_or_MEM !== 2'b00 || data_out !== 32'h0) begin
            bad++;
            $display("FAIL %s_strobe_len: done=%b tag=%b data=%h, want 0 00 0", name, done_out,
                     IF_or_MEM, data_out);
        end
    endtask

    task automatic test_store();
        int cyc;
        rw_in = 2'b10; addr_mem_in = 32'h200; data_length_in = 3'd2; data_mem_in = 32'hAABBCCDD;
        @(negedge clk);
        rw_in = 2'b00; data_mem_in = 32'h0;
        wait_done(cyc);
        total++;
        if (cyc !== 2) begin
            bad++; $display("FAIL sh_latency: got %0d cycles, want 2", cyc);
        end
        total++;
        if (tr_addr[0] !== 32'h200 || tr_wr[0] !== 1'b1 || tr_dout[0] !== 8'hDD ||
            tr_addr[1] !== 32'h201 || tr_wr[1] !== 1'b1 || tr_dout[1] !== 8'hCC) begin
            bad++;
            $display("FAIL sh_bytes: %h/%b/%h %h/%b/%h, want 200/1/dd 201/1/cc", tr_addr[0],
                     tr_wr[0], tr_dout[0], tr_addr[1], tr_wr[1], tr_dout[1]);
        end
        total++;
        if (data_out !== 32'h0 || IF_or_MEM !== 2'b01 || ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL sh_done: data=%h tag=%b wr=%b, want 0 01 0", data_out, IF_or_MEM,
                     ram_wr);
        end
        @(negedge clk);
        total++;
        if (mem[12'h200] !== 8'hDD || mem[12'h201] !== 8'hCC || mem[12'h202] !== 8'h33) begin
            bad++;
            $display("FAIL sh_ram: %h %h %h, want dd cc 33", mem[12'h200], mem[12'h201],
                     mem[12'h202]);
        end
    endtask

    task automatic test_arbitration();
        int cyc;
        rw_in = 2'b01; addr_mem_in = 32'h10; data_length_in = 3'd1;
        if_req_in = 1'b1; if_addr_in = 32'h0;
        @(negedge clk);
        rw_in = 2'b00;
        wait_done(cyc);
        total++;
        if (cyc !== 2 || IF_or_MEM !== 2'b01 || data_out !== 32'h0000_005A) begin
            bad++;
            $display("FAIL arb_mem_first: cyc=%0d tag=%b data=%h, want 2 01 0000005a", cyc,
                     IF_or_MEM, data_out);
        end
        @(negedge clk);
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            bad++;
            $display("FAIL arb_idle_gap: busy=%b done=%b, want 0 0", busy_out, done_out);
        end
        @(negedge clk);
        if_req_in = 1'b0; if_addr_in = 32'h0000_0800;
        total++;
        if (busy_out !== 1'b1 || ram_addr !== 32'h0) begin
            bad++;
            $display("FAIL arb_if_start: busy=%b addr=%h, want 1 00000000", busy_out, ram_addr);
        end
        wait_done(cyc);
        total++;
        if (cyc !== 5 || IF_or_MEM !== 2'b10 || data_out !== 32'hD4C3B2A1 ||
            tr_addr[3] !== 32'h3) begin
            bad++;
            $display("FAIL arb_if_done: cyc=%0d tag=%b data=%h a3=%h, want 5 10 d4c3b2a1 3",
                     cyc, IF_or_MEM, data_out, tr_addr[3]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        rw_in = 2'b01; addr_mem_in = 32'h100; data_length_in = 3'd4;
        @(negedge clk);
        rw_in = 2'b00;
        @(negedge clk);
        total++;
        if (busy_out !== 1'b1 || ram_addr !== 32'h101) begin
            bad++;
            $display("FAIL rst_mid_busy: busy=%b addr=%h, want 1 00000101", busy_out, ram_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || IF_or_MEM !== 2'b00 || ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle: busy=%b done=%b tag=%b wr=%b, want 0 0 00 0", busy_out,
                     done_out, IF_or_MEM, ram_wr);
        end
        repeat (6) begin
            @(negedge clk);
            total++;
            if (done_out !== 1'b0 || busy_out !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_no_done: done=%b busy=%b, want 0 0", done_out, busy_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rw_in = 2'b00; addr_mem_in = '0; data_length_in = 3'd1; data_mem_in = '0;
        if_req_in = 1'b0; if_addr_in = '0;
        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        poke(12'h200, 8'h11); poke(12'h201, 8'h22); poke(12'h202, 8'h33);
        poke(12'h010, 8'h5A);
        poke(12'h000, 8'hA1); poke(12'h001, 8'hB2); poke(12'h002, 8'hC3); poke(12'h003, 8'hD4);
        poke(12'hFFF, 8'hEF);

        test_reset();
        test_load("lw", 32'h100, 3'd4, 4, 32'h12345678);
        test_load("lb", 32'h102, 3'd1, 1, 32'h00000034);
        test_load("len3", 32'h100, 3'd3, 4, 32'h12345678);
        test_store();
        test_arbitration();
        test_load("wrap", 32'hFFFF_FFFF, 3'd2, 2, 32'h0000_A1EF);
        test_reset_mid_read();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the CPU memory request interface. Serves MEM-stage load/store requests and IF-stage instruction fetches.
- Serializes each 1/2/4-byte access onto a byte-wide, synchronous-read RAM port.
- Reports completion through busy/done/data and a source tag (IF_or_MEM) that the requesting stage matches.
- Sits between the pipeline stages and the RAM.

Parameters:
- ADDR_W, 32, width of request addresses and of the RAM address output.
- IF_LEN, 4, byte count of every IF fetch.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rw_in  in  2  MEM request: 00 none, 01 read, 10 write, 11 treated as none
- addr_mem_in  in  ADDR_W  MEM byte address
- data_length_in  in  3  MEM byte count (1, 2 or 4)
- data_mem_in  in  32  MEM store data, little-endian, low bytes used
- if_req_in  in  1  IF fetch request
- if_addr_in  in  ADDR_W  IF fetch address
- busy_out  out  1  transaction in progress
- done_out  out  1  one-cycle completion strobe
- IF_or_MEM  out  2  completion tag: 01 MEM, 10 IF, 00 none
- data_out  out  32  read data, zero-extended
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write enable
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid the cycle after its address

Behaviour:
- Reset is rst, synchronous, active-high. On a reset edge:
  - state=IDLE;
  - busy_out, done_out, ram_wr, ram_dout, ram_addr, data_out = 0;
  - IF_or_MEM=00.
- Reset mid-transaction aborts it with no completion strobe. ram_wr is 0 from the cycle after the reset edge.
- States: IDLE, READ, WRITE, DONE. All outputs are functions of registered state and counters only; there is no combinational path from request inputs to outputs.
- IDLE:
  - busy=0, done=0, tag=00, ram_wr=0.
  - At a clock edge, the controller samples requests. MEM has priority over IF.
  - Latch base address, length (IF: IF_LEN), store data and source tag. Clear byte counter cnt and capture counter.
  - Next state: READ for rw=01 or if_req; WRITE for rw=10.
  - A length not in {1,2,4} is served as 4.
- READ:
  - busy=1. ram_addr=base+cnt (ADDR_W wrap-around); cnt advances each cycle while cnt<len.
  - Each byte is captured one cycle after issue into data[8*k+7:8*k], k = capture index.
  - When the last byte is captured, go to DONE.
  - An N-byte read occupies N+1 READ cycles.
- WRITE:
  - busy=1, ram_wr=1, ram_addr=base+cnt, ram_dout=store_data[8*cnt+7:8*cnt].
  - After N cycles, go to DONE with ram_wr=0 in DONE.
- DONE:
  - Exactly one cycle: busy=0, done=1, tag=latched source.
  - data_out = assembled read data with upper unused bytes 0; for writes data_out=0.
  - Always returns to IDLE and never accepts a request in this cycle. A requester still holding rw/if_req is re-sampled only in the following IDLE cycle.
- Request inputs change while busy: ignored, because the latched copies are used.
- Simultaneous MEM and IF requests in IDLE: MEM is served first. IF is served from the next IDLE if still asserted.
- Total latency, request-sampling edge to DONE:
  - read: N+1 cycles;
  - write: N cycles;
  - plus the DONE cycle.
- Sign extension for LB/LH is not done here; data is always zero-extended.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles → all outputs 0, tag=00; with no requests, state stays IDLE.
- MEM LW: RAM[0x100..0x103]=78 56 34 12, rw=01, addr=0x100, len=4 → ram_addr steps 0x100..0x103. DONE five cycles after sampling with data_out=0x12345678, tag=01, busy=0 for one cycle.
- MEM SH: rw=10, addr=0x200, len=2, data=0xAABBCCDD → two ram_wr cycles writing 0xDD@0x200 and 0xCC@0x201, then DONE with tag=01, data_out=0. RAM[0x202] is unchanged.
- Arbitration: if_req=1 (addr 0x0) and rw=01 (addr 0x10, len 1) in the same IDLE cycle → MEM byte served first (tag=01); IF served next with tag=10 and 4 bytes from 0x0.
- Wrap: LH at addr 0xFFFFFFFF → bytes read from 0xFFFFFFFF then 0x00000000, zero-extended into data_out[15:0].
- Reset mid-read: rst asserted during the 2nd byte of an LW → next cycle IDLE, no done strobe, busy=0, tag=00.
